// File: rtl/dds_pkg.sv
// Shared DDS wave-table constants and capture FSM state encoding.
package dds_pkg;

  localparam int unsigned WAVE_ADDR_W = 6;
  localparam int unsigned WAVE_DEPTH  = 1 << WAVE_ADDR_W;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_TRIG = 2'd1;
  localparam logic [1:0] ST_CAPTURE   = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

endpackage

// File: rtl/dds_capture_ram.sv
// DEPTH x 1 capture table: one synchronous write port, one registered read port.
module dds_capture_ram
  import dds_pkg::*;
#(
  parameter int unsigned ADDR_W = WAVE_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic mem [DEPTH];

  // Contents are deliberately not reset so a partial capture survives a reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Same-address write and read in one cycle returns the old sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= 1'b0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/dds_wave_capture.sv
// Captures DEPTH consecutive DDS output samples after a rising-edge trigger.
// Optional wave period measurement is enabled by defining DDS_CAPTURE_PERIOD_EN.
module dds_wave_capture
  import dds_pkg::*;
#(
  parameter int unsigned ADDR_W   = WAVE_ADDR_W,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wave_in,
  input  logic                arm,
  output logic                busy,
  output logic                done,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_data,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);

  localparam int unsigned       DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  logic              wave_d;
  logic              rise;
  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] wr_ptr_next;
  logic [ADDR_W-1:0] wr_addr;
  logic              we;
  logic              wr_data;

  assign rise = wave_in & ~wave_d;

  // wave_d resets high so a wave already high at reset release is not a rise.
  always_ff @(posedge clock) begin
    if (reset) begin
      wave_d <= 1'b1;
    end else begin
      wave_d <= wave_in;
    end
  end

  // State, write pointer and registered status decodes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      wr_ptr <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      wr_ptr <= wr_ptr_next;
      busy   <= (state == ST_WAIT_TRIG) || (state == ST_CAPTURE);
      done   <= (state == ST_DONE);
    end
  end

  // Next state and table write control.
  always_comb begin
    state_next  = state;
    wr_ptr_next = wr_ptr;
    we          = 1'b0;
    wr_addr     = wr_ptr;
    wr_data     = wave_in;
    case (state)
      ST_IDLE: begin
        if (arm) begin
          state_next = ST_WAIT_TRIG;
        end
      end
      ST_WAIT_TRIG: begin
        if (rise) begin
          we          = 1'b1;
          wr_addr     = '0;
          wr_data     = 1'b1;
          wr_ptr_next = ADDR_W'(1);
          state_next  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        we          = 1'b1;
        wr_ptr_next = wr_ptr + ADDR_W'(1);
        if (wr_ptr == LAST) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (arm) begin
          wr_ptr_next = '0;
          state_next  = ST_WAIT_TRIG;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  dds_capture_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .we      (we & ~reset),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef DDS_CAPTURE_PERIOD_EN
  logic [PERIOD_W-1:0] cnt;
  logic                seen;

  // Free-running, saturating cycle counter restarted on every rise.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt          <= '0;
      seen         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (rise) begin
        cnt  <= PERIOD_W'(1);
        seen <= 1'b1;
        if (seen) begin
          period       <= cnt;
          period_valid <= 1'b1;
        end
      end else if (cnt != {PERIOD_W{1'b1}}) begin
        cnt <= cnt + PERIOD_W'(1);
      end
    end
  end
`else
  assign period       = PERIOD_W'(0);
  assign period_valid = 1'b0;
`endif

endmodule
